// File: rtl/pci_mon_pkg.sv
// Shared types, check indices and helpers for the PCI protocol monitor.
package pci_mon_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StAddr  = 3'd1,
        StWait  = 3'd2,
        StData  = 3'd3,
        StLast  = 3'd4,
        StAbort = 3'd5,
        StTurn  = 3'd6
    } pci_state_e;

    localparam int unsigned CHK_FRM_IRDY    = 0;
    localparam int unsigned CHK_TRDY_DEVSEL = 1;
    localparam int unsigned CHK_CBE_STABLE  = 2;
    localparam int unsigned CHK_IRDY_DROP   = 3;
    localparam int unsigned CHK_FRM_LAST    = 4;
    localparam int unsigned CHK_ORPHAN      = 5;
    localparam int unsigned NUM_CHK         = 6;

    // A data phase completes when IRDY_ is low together with TRDY_ or STOP_.
    function automatic logic phase_done(input logic irdy_n, input logic trdy_n,
                                        input logic stop_n);
        return ~irdy_n & (~trdy_n | ~stop_n);
    endfunction

endpackage

// File: rtl/pci_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pci_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pci_protocol_monitor.sv
// Passive PCI bus monitor: tracks the bus phase, flags protocol violations and
// master aborts, and keeps sticky flags plus saturating event counters.
module pci_protocol_monitor
    import pci_mon_pkg::*;
#(
    parameter int unsigned         AD_W       = 32,
    parameter int unsigned         BE_W       = AD_W / 8,
    parameter int unsigned         DEVSEL_TMO = 5,
    parameter int unsigned         CNT_W      = 16,
    parameter logic [NUM_CHK-1:0]  CHK_EN     = 6'b111111
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               FRAME_,
    input  logic               IRDY_,
    input  logic               TRDY_,
    input  logic               DEVSEL_,
    input  logic               STOP_,
    input  logic [BE_W-1:0]    C_BE_,
    input  logic [AD_W-1:0]    AD,
    input  logic               clr,
    output logic [NUM_CHK-1:0] viol_pulse,
    output logic [NUM_CHK-1:0] viol_sticky,
    output logic [CNT_W-1:0]   viol_count,
    output logic [CNT_W-1:0]   txn_count,
    output logic               master_abort,
    output logic [2:0]         bus_state
);

    localparam logic [3:0] TMO_LAST = 4'(DEVSEL_TMO - 1);

    pci_state_e        r_state;
    logic [3:0]        r_wait_cnt;
    logic              r_master_abort;
    logic              r_p_frame, r_p_irdy, r_p_trdy, r_p_stop;
    logic [BE_W-1:0]   r_p_cbe;
    logic [NUM_CHK-1:0] r_viol_pulse, r_viol_sticky;

    logic               w_done, w_frame_fall, w_p_stall, w_in_data, w_txn_inc;
    logic [NUM_CHK-1:0] w_raw, w_pulse;
    logic               w_unused_ad;

    assign w_unused_ad  = ^AD;
    assign w_done       = phase_done(IRDY_, TRDY_, STOP_);
    assign w_frame_fall = r_p_frame & ~FRAME_;
    // Previous cycle was a wait state: master ready, target neither ready nor stopping.
    assign w_p_stall    = ~r_p_irdy & r_p_trdy & r_p_stop;
    assign w_in_data    = (r_state == StData) || (r_state == StLast);
    assign w_txn_inc    = (r_state == StLast) && w_done;

    always_comb begin
        w_raw = '0;
        w_raw[CHK_FRM_IRDY]    = FRAME_ & ~r_p_frame & IRDY_;
        w_raw[CHK_TRDY_DEVSEL] = ~TRDY_ & DEVSEL_;
        w_raw[CHK_CBE_STABLE]  = w_in_data & w_p_stall & (C_BE_ != r_p_cbe);
        w_raw[CHK_IRDY_DROP]   = IRDY_ & w_p_stall;
        w_raw[CHK_FRM_LAST]    = (r_state == StLast) & w_frame_fall;
        w_raw[CHK_ORPHAN]      = (r_state == StIdle) & FRAME_ & ~IRDY_;
    end

    assign w_pulse = w_raw & CHK_EN;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p_frame <= 1'b1;
            r_p_irdy  <= 1'b1;
            r_p_trdy  <= 1'b1;
            r_p_stop  <= 1'b1;
            r_p_cbe   <= '0;
        end else begin
            r_p_frame <= FRAME_;
            r_p_irdy  <= IRDY_;
            r_p_trdy  <= TRDY_;
            r_p_stop  <= STOP_;
            r_p_cbe   <= C_BE_;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= StIdle;
            r_wait_cnt     <= '0;
            r_master_abort <= 1'b0;
        end else begin
            r_master_abort <= 1'b0;
            case (r_state)
                StIdle:  if (w_frame_fall) r_state <= StAddr;
                StAddr: begin
                    r_state    <= StWait;
                    r_wait_cnt <= 4'd1;
                end
                StWait: begin
                    if (!DEVSEL_) begin
                        r_state <= StData;
                    end else if (r_wait_cnt == TMO_LAST) begin
                        r_state        <= StAbort;
                        r_master_abort <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                StData:  if (FRAME_) r_state <= StLast;
                StLast:  if (w_done) r_state <= StTurn;
                StAbort: if (FRAME_ && IRDY_) r_state <= StTurn;
                StTurn:  r_state <= w_frame_fall ? StAddr : StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_viol_pulse  <= '0;
            r_viol_sticky <= '0;
        end else begin
            r_viol_pulse  <= w_pulse;
            r_viol_sticky <= clr ? '0 : (r_viol_sticky | w_pulse);
        end
    end

    pci_sat_counter #(
        .WIDTH (CNT_W)
    ) u_viol_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_inc   (|w_pulse),
        .i_clr   (clr),
        .o_count (viol_count)
    );

    pci_sat_counter #(
        .WIDTH (CNT_W)
    ) u_txn_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_inc   (w_txn_inc),
        .i_clr   (clr),
        .o_count (txn_count)
    );

    assign viol_pulse   = r_viol_pulse;
    assign viol_sticky  = r_viol_sticky;
    assign master_abort = r_master_abort;
    assign bus_state    = r_state;

endmodule

// File: tb/tb_pci_protocol_monitor.sv
// Directed bench: a default monitor and a narrow-counter, check-1-masked monitor
// watch the same bus; table vectors plus hand-written abort/saturation/reset cases.
module tb_pci_protocol_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_n, irdy_n, trdy_n, devsel_n, stop_n, clr;
    logic [3:0]  cbe;
    logic [31:0] ad;

    logic [5:0]  a_pulse, a_sticky, b_pulse, b_sticky;
    logic [15:0] a_vcnt, a_tcnt;
    logic [3:0]  b_vcnt, b_tcnt;
    logic        a_ma, b_ma;
    logic [2:0]  a_st, b_st;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pci_protocol_monitor dut_a (
        .clk (clk), .reset (reset), .FRAME_ (frame_n), .IRDY_ (irdy_n), .TRDY_ (trdy_n),
        .DEVSEL_ (devsel_n), .STOP_ (stop_n), .C_BE_ (cbe), .AD (ad), .clr (clr),
        .viol_pulse (a_pulse), .viol_sticky (a_sticky), .viol_count (a_vcnt),
        .txn_count (a_tcnt), .master_abort (a_ma), .bus_state (a_st)
    );

    pci_protocol_monitor #(
        .CNT_W  (4),
        .CHK_EN (6'b111101)
    ) dut_b (
        .clk (clk), .reset (reset), .FRAME_ (frame_n), .IRDY_ (irdy_n), .TRDY_ (trdy_n),
        .DEVSEL_ (devsel_n), .STOP_ (stop_n), .C_BE_ (cbe), .AD (ad), .clr (clr),
        .viol_pulse (b_pulse), .viol_sticky (b_sticky), .viol_count (b_vcnt),
        .txn_count (b_tcnt), .master_abort (b_ma), .bus_state (b_st)
    );

    typedef struct {
        logic       f, i, t, d, s;
        logic [3:0] cbe;
        logic [2:0] st;
        logic [5:0] pa, pb;
        int         txn, va, vb;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic f, input logic i, input logic t, input logic d,
                       input logic s, input logic [3:0] c, input logic [2:0] st,
                       input logic [5:0] pa, input logic [5:0] pb,
                       input int txn, input int va, input int vb);
        vec_t v;
        v.f = f; v.i = i; v.t = t; v.d = d; v.s = s; v.cbe = c; v.st = st;
        v.pa = pa; v.pb = pb; v.txn = txn; v.va = va; v.vb = vb;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic f, input logic i, input logic t, input logic d,
                         input logic [3:0] c);
        frame_n = f; irdy_n = i; trdy_n = t; devsel_n = d; stop_n = 1'b1; cbe = c;
        ad = ad + 32'h11;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; ad = 32'hA5A5_0000;
        drive(1, 1, 1, 1, 4'h0);
        #1;
        chk("reset_state", {29'd0, a_st}, 32'd0);
        chk("reset_pulse", {26'd0, a_pulse}, 32'd0);
        chk("reset_vcnt", {16'd0, a_vcnt}, 32'd0);
        chk("reset_ma", {31'd0, a_ma}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();

        //  f  i  t  d  s  cbe   st  pa         pb         txn va vb
        add(1, 1, 1, 1, 1, 4'h0, 0, 6'b000000, 6'b000000, 0, 0, 0);
        add(0, 1, 1, 1, 1, 4'h0, 1, 6'b000000, 6'b000000, 0, 0, 0);
        add(0, 1, 1, 1, 1, 4'h0, 2, 6'b000000, 6'b000000, 0, 0, 0);
        add(0, 1, 1, 0, 1, 4'h0, 3, 6'b000000, 6'b000000, 0, 0, 0);
        add(1, 0, 0, 0, 1, 4'h0, 4, 6'b000000, 6'b000000, 0, 0, 0);
        add(1, 0, 0, 0, 1, 4'h0, 6, 6'b000000, 6'b000000, 1, 0, 0);
        add(1, 1, 1, 1, 1, 4'h0, 0, 6'b000000, 6'b000000, 1, 0, 0);
        add(0, 1, 1, 1, 1, 4'h0, 1, 6'b000000, 6'b000000, 1, 0, 0);
        add(1, 1, 1, 1, 1, 4'h0, 2, 6'b000001, 6'b000001, 1, 1, 1);
        add(1, 1, 1, 0, 1, 4'h0, 3, 6'b000000, 6'b000000, 1, 1, 1);
        add(1, 0, 0, 0, 1, 4'h0, 4, 6'b000000, 6'b000000, 1, 1, 1);
        add(1, 0, 0, 0, 1, 4'h0, 6, 6'b000000, 6'b000000, 2, 1, 1);
        add(0, 1, 1, 1, 1, 4'h0, 1, 6'b000000, 6'b000000, 2, 1, 1);
        add(0, 1, 1, 1, 1, 4'h0, 2, 6'b000000, 6'b000000, 2, 1, 1);
        add(0, 0, 1, 0, 1, 4'h0, 3, 6'b000000, 6'b000000, 2, 1, 1);
        add(0, 0, 1, 0, 1, 4'h0, 3, 6'b000000, 6'b000000, 2, 1, 1);
        add(0, 1, 1, 0, 1, 4'hF, 3, 6'b001100, 6'b001100, 2, 2, 2);
        add(1, 0, 0, 0, 1, 4'hF, 4, 6'b000000, 6'b000000, 2, 2, 2);
        add(1, 0, 0, 0, 1, 4'hF, 6, 6'b000000, 6'b000000, 3, 2, 2);
        add(1, 1, 1, 1, 1, 4'h0, 0, 6'b000000, 6'b000000, 3, 2, 2);
        add(1, 1, 0, 1, 1, 4'h0, 0, 6'b000010, 6'b000000, 3, 3, 2);
        add(1, 1, 1, 1, 1, 4'h0, 0, 6'b000000, 6'b000000, 3, 3, 2);
        add(1, 0, 1, 1, 1, 4'h0, 0, 6'b100000, 6'b100000, 3, 4, 3);
        add(1, 1, 1, 1, 1, 4'h0, 0, 6'b001000, 6'b001000, 3, 5, 4);
        add(1, 1, 1, 1, 1, 4'h0, 0, 6'b000000, 6'b000000, 3, 5, 4);

        for (int n = 0; n < vecs.size(); n++) begin
            drive(vecs[n].f, vecs[n].i, vecs[n].t, vecs[n].d, vecs[n].cbe);
            stop_n = vecs[n].s;
            tick();
            chk($sformatf("v%0d_state", n), {29'd0, a_st}, {29'd0, vecs[n].st});
            chk($sformatf("v%0d_pulse_a", n), {26'd0, a_pulse}, {26'd0, vecs[n].pa});
            chk($sformatf("v%0d_pulse_b", n), {26'd0, b_pulse}, {26'd0, vecs[n].pb});
            chk($sformatf("v%0d_txn", n), {16'd0, a_tcnt}, vecs[n].txn);
            chk($sformatf("v%0d_vcnt_a", n), {16'd0, a_vcnt}, vecs[n].va);
            chk($sformatf("v%0d_vcnt_b", n), {28'd0, b_vcnt}, vecs[n].vb);
            chk($sformatf("v%0d_ma", n), {31'd0, a_ma}, 32'd0);
        end
        chk("sticky_a", {26'd0, a_sticky}, 32'b101111);
        chk("sticky_b", {26'd0, b_sticky}, 32'b101101);

        // Master abort: DEVSEL_ never asserted.
        drive(0, 1, 1, 1, 4'h0);
        tick();
        chk("abort_addr", {29'd0, a_st}, 32'd1);
        drive(0, 0, 1, 1, 4'h0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("abort_k%0d_state", k), {29'd0, a_st}, (k < 5) ? 32'd2 : 32'd5);
            chk($sformatf("abort_k%0d_ma", k), {31'd0, a_ma}, (k == 5) ? 32'd1 : 32'd0);
        end
        drive(1, 0, 1, 1, 4'h0);
        tick();
        chk("abort_hold", {29'd0, a_st}, 32'd5);
        drive(1, 1, 1, 1, 4'h0);
        tick();
        chk("abort_turn", {29'd0, a_st}, 32'd6);
        chk("abort_txn", {16'd0, a_tcnt}, 32'd3);
        chk("abort_irdy_drop", {26'd0, a_pulse}, 32'b001000);
        tick();
        chk("abort_idle", {29'd0, a_st}, 32'd0);

        // Clear, then saturate the 4-bit counter.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_vcnt_a", {16'd0, a_vcnt}, 32'd0);
        chk("clr_vcnt_b", {28'd0, b_vcnt}, 32'd0);
        chk("clr_sticky", {26'd0, a_sticky}, 32'd0);
        chk("clr_txn", {16'd0, a_tcnt}, 32'd0);
        drive(1, 0, 1, 1, 4'h0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("sat_k%0d_a", k), {16'd0, a_vcnt}, k);
            chk($sformatf("sat_k%0d_b", k), {28'd0, b_vcnt}, (k > 15) ? 32'd15 : k);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clrviol_vcnt_b", {28'd0, b_vcnt}, 32'd0);
        chk("clrviol_sticky_b", {26'd0, b_sticky}, 32'd0);
        chk("clrviol_pulse_b", {26'd0, b_pulse}, 32'b100000);
        drive(1, 1, 1, 1, 4'h0);
        tick();
        chk("postclr_pulse", {26'd0, a_pulse}, 32'b001000);
        chk("postclr_vcnt", {16'd0, a_vcnt}, 32'd1);
        chk("postclr_sticky", {26'd0, a_sticky}, 32'b001000);

        // Reset asserted while in DATA.
        drive(0, 1, 1, 1, 4'h0);
        tick();
        tick();
        drive(0, 1, 1, 0, 4'h0);
        tick();
        chk("rst_pre_state", {29'd0, a_st}, 32'd3);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_state", {29'd0, a_st}, 32'd0);
        chk("rst_async_vcnt", {16'd0, a_vcnt}, 32'd0);
        chk("rst_async_sticky", {26'd0, a_sticky}, 32'd0);
        chk("rst_async_state_b", {29'd0, b_st}, 32'd0);
        drive(1, 1, 1, 1, 4'h0);
        #2 reset = 1'b0;
        tick();
        chk("rst_after_state", {29'd0, a_st}, 32'd0);
        chk("rst_after_pulse", {26'd0, a_pulse}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
